// File: rtl/eth_burst_align_read_pkg.sv
// ---------------------------------------------------------------------------
// eth_burst_align_read_pkg
// Shared definitions for the Ethernet DMA read path:
//   - state_t          : read-aligner FSM state encoding
//   - AXI_SIZE_4B      : AXI ARSIZE for 4-byte beats
//   - AXI_BURST_INCR   : AXI ARBURST encoding for INCR bursts
//   - BURST_MAX_BYTES  : largest byte span (offset + length) one burst covers
//   - last_strb()      : byte-enable pattern of the final word from len[1:0]
// ---------------------------------------------------------------------------
package eth_burst_align_read_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ADDR  = 2'd1,
        ST_DATA  = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    localparam logic [2:0] AXI_SIZE_4B     = 3'b010;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam int         BURST_MAX_BYTES = 1024;

    // A length that is a multiple of 4 fills the last word completely.
    function automatic logic [3:0] last_strb(input logic [1:0] len_lsb);
        logic [3:0] strb;
        case (len_lsb)
            2'd1:    strb = 4'b0001;
            2'd2:    strb = 4'b0011;
            2'd3:    strb = 4'b0111;
            default: strb = 4'b1111;
        endcase
        return strb;
    endfunction

endpackage

// File: rtl/eth_byte_realign.sv
// ---------------------------------------------------------------------------
// eth_byte_realign
// Shifts word-aligned read beats into a byte-packed stream.
//   clk, rst   : clock, asynchronous active-high reset
//   clr        : clear the stored bytes (new transfer)
//   load       : capture the upper (4-offset) bytes of rdata into the store
//   offset     : byte offset of the region start within the first beat
//   rdata      : current read beat
//   flush_sel  : emit only the stored bytes (no beat left to merge with)
//   out_en     : an output word is being presented this cycle
//   last_word  : the presented word is the final word of the transfer
//   len_lsb    : len[1:0] of the transfer, selects the final strobe
//   data_out   : realigned word, bytes outside data_strb forced to 0
//   data_strb  : valid bytes of data_out (0 when out_en is low)
// ---------------------------------------------------------------------------
module eth_byte_realign
    import eth_burst_align_read_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        load,
    input  logic [1:0]  offset,
    input  logic [31:0] rdata,
    input  logic        flush_sel,
    input  logic        out_en,
    input  logic        last_word,
    input  logic [1:0]  len_lsb,
    output logic [31:0] data_out,
    output logic [3:0]  data_strb
);

    logic [23:0] st_q, st_d;
    logic [31:0] raw;
    logic [31:0] byte_mask;

    // Stored bytes are always kept right-justified so the merge below is a
    // plain concatenation and the flush word is simply the store itself.
    always_comb begin
        st_d = st_q;
        if (clr) begin
            st_d = '0;
        end else if (load) begin
            case (offset)
                2'd1:    st_d = rdata[31:8];
                2'd2:    st_d = {8'h00, rdata[31:16]};
                2'd3:    st_d = {16'h0000, rdata[31:24]};
                default: st_d = st_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q <= '0;
        end else begin
            st_q <= st_d;
        end
    end

    always_comb begin
        raw = 32'h0;
        if (flush_sel) begin
            raw = {8'h00, st_q};
        end else begin
            case (offset)
                2'd0:    raw = rdata;
                2'd1:    raw = {rdata[7:0],  st_q[23:0]};
                2'd2:    raw = {rdata[15:0], st_q[15:0]};
                default: raw = {rdata[23:0], st_q[7:0]};
            endcase
        end
    end

    always_comb begin
        data_strb = 4'b0000;
        if (out_en) begin
            data_strb = last_word ? last_strb(len_lsb) : 4'b1111;
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_mask
            assign byte_mask[8*gi +: 8] = {8{data_strb[gi]}};
        end
    endgenerate

    assign data_out = raw & byte_mask;

endmodule

// File: rtl/eth_burst_align_read.sv
// ---------------------------------------------------------------------------
// eth_burst_align_read
// Reads a byte region at an arbitrary byte address with one AXI4 INCR burst
// of 4-byte beats and presents it as a byte-packed 32-bit stream where byte 0
// of the region is always data_out[7:0] of the first word.
//   clk, rst         : clock, asynchronous active-high reset
//   start/addr/len   : request (sampled in IDLE only)
//   busy/done/err    : status; err flags an rlast/beat-count disagreement
//   m_axi_ar*        : read address channel
//   m_axi_r*         : read data channel
//   data_*           : realigned output stream with byte strobes and last
// ---------------------------------------------------------------------------
module eth_burst_align_read
    import eth_burst_align_read_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] addr,
    input  logic [9:0]        len,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] m_axi_araddr,
    output logic [7:0]        m_axi_arlen,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    input  logic [31:0]       m_axi_rdata,
    input  logic              m_axi_rvalid,
    input  logic              m_axi_rlast,
    output logic              m_axi_rready,
    output logic [31:0]       data_out,
    output logic              data_valid,
    input  logic              data_ready,
    output logic [3:0]        data_strb,
    output logic              data_last
);

    state_t            state_q, state_d;
    logic [1:0]        off_q, off_d;
    logic [1:0]        len_lsb_q, len_lsb_d;
    logic [10:0]       beats_q, beats_d;
    logic [10:0]       words_q, words_d;
    logic [10:0]       beat_cnt_q, beat_cnt_d;
    logic [10:0]       word_cnt_q, word_cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              arvalid_q, arvalid_d;
    logic [ADDR_W-1:0] araddr_q, araddr_d;
    logic [7:0]        arlen_q, arlen_d;

    logic [10:0]       span;
    logic [10:0]       beats_new;
    logic              start_ok;
    logic              absorb;
    logic              r_hs;
    logic              out_hs;
    logic              last_word;
    logic              in_data;

    assign span      = {9'd0, addr[1:0]} + {1'b0, len};
    assign beats_new = (span + 11'd3) >> 2;
    assign start_ok  = (state_q == ST_IDLE) && start && (len != 10'd0)
                       && (span <= 11'(BURST_MAX_BYTES));

    // With a non-zero offset the first beat only holds the head of byte 0's
    // word, so it is swallowed into the store regardless of the consumer.
    assign in_data      = (state_q == ST_DATA);
    assign absorb       = in_data && (off_q != 2'd0) && (beat_cnt_q == 11'd0);
    assign m_axi_rready = in_data && (absorb || data_ready);
    assign data_valid   = (in_data && !absorb && m_axi_rvalid) || (state_q == ST_FLUSH);
    assign r_hs         = m_axi_rvalid && m_axi_rready;
    assign out_hs       = data_valid && data_ready;
    assign last_word    = (word_cnt_q == words_q - 11'd1);
    assign data_last    = data_valid && last_word;

    always_comb begin
        state_d    = state_q;
        off_d      = off_q;
        len_lsb_d  = len_lsb_q;
        beats_d    = beats_q;
        words_d    = words_q;
        beat_cnt_d = beat_cnt_q;
        word_cnt_d = word_cnt_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = err_q;
        arvalid_d  = arvalid_q;
        araddr_d   = araddr_q;
        arlen_d    = arlen_q;

        case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    off_d      = addr[1:0];
                    len_lsb_d  = len[1:0];
                    beats_d    = beats_new;
                    words_d    = ({1'b0, len} + 11'd3) >> 2;
                    beat_cnt_d = '0;
                    word_cnt_d = '0;
                    arlen_d    = beats_new[7:0] - 8'd1;
                    araddr_d   = {addr[ADDR_W-1:2], 2'b00};
                    arvalid_d  = 1'b1;
                    busy_d     = 1'b1;
                    err_d      = 1'b0;
                    state_d    = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (m_axi_arready) begin
                    arvalid_d = 1'b0;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (out_hs) begin
                    word_cnt_d = word_cnt_q + 11'd1;
                end
                if (r_hs) begin
                    beat_cnt_d = beat_cnt_q + 11'd1;
                    if (m_axi_rlast != (beat_cnt_q == beats_q - 11'd1)) begin
                        err_d = 1'b1;
                    end
                    // The slave's rlast ends the burst even when it disagrees
                    // with our count; a trailing partial word may still be
                    // sitting in the store when the burst had no extra beat.
                    if (m_axi_rlast) begin
                        if ((off_q != 2'd0) && (beats_q == words_q)) begin
                            state_d = ST_FLUSH;
                        end else begin
                            state_d = ST_IDLE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end
                    end
                end
            end
            ST_FLUSH: begin
                if (data_ready) begin
                    word_cnt_d = word_cnt_q + 11'd1;
                    state_d    = ST_IDLE;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            off_q      <= '0;
            len_lsb_q  <= '0;
            beats_q    <= '0;
            words_q    <= '0;
            beat_cnt_q <= '0;
            word_cnt_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            arvalid_q  <= 1'b0;
            araddr_q   <= '0;
            arlen_q    <= '0;
        end else begin
            state_q    <= state_d;
            off_q      <= off_d;
            len_lsb_q  <= len_lsb_d;
            beats_q    <= beats_d;
            words_q    <= words_d;
            beat_cnt_q <= beat_cnt_d;
            word_cnt_q <= word_cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            arvalid_q  <= arvalid_d;
            araddr_q   <= araddr_d;
            arlen_q    <= arlen_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arlen   = arlen_q;

    eth_byte_realign u_realign (
        .clk       (clk),
        .rst       (rst),
        .clr       (start_ok),
        .load      (r_hs && (off_q != 2'd0)),
        .offset    (off_q),
        .rdata     (m_axi_rdata),
        .flush_sel (state_q == ST_FLUSH),
        .out_en    (data_valid),
        .last_word (last_word),
        .len_lsb   (len_lsb_q),
        .data_out  (data_out),
        .data_strb (data_strb)
    );

endmodule

// File: tb/tb_eth_burst_align_read.sv
// ---------------------------------------------------------------------------
// tb_eth_burst_align_read
// Drives eth_burst_align_read against a byte-addressed memory behind a simple
// AXI read slave. Expected output words are built directly from the memory
// bytes of the requested region (byte k of the region -> word k/4, lane k%4).
// ---------------------------------------------------------------------------
module tb_eth_burst_align_read;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] addr;
    logic [9:0]  len;
    logic        busy, done, err;
    logic [31:0] m_axi_araddr;
    logic [7:0]  m_axi_arlen;
    logic        m_axi_arvalid, m_axi_arready;
    logic [31:0] m_axi_rdata;
    logic        m_axi_rvalid, m_axi_rlast, m_axi_rready;
    logic [31:0] data_out;
    logic        data_valid, data_ready;
    logic [3:0]  data_strb;
    logic        data_last;

    always #5 clk = ~clk;

    eth_burst_align_read #(.ADDR_W(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .addr          (addr),
        .len           (len),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arlen   (m_axi_arlen),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_arready (m_axi_arready),
        .m_axi_rdata   (m_axi_rdata),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rlast   (m_axi_rlast),
        .m_axi_rready  (m_axi_rready),
        .data_out      (data_out),
        .data_valid    (data_valid),
        .data_ready    (data_ready),
        .data_strb     (data_strb),
        .data_last     (data_last)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    logic [7:0]  mem [0:4095];
    logic [31:0] exp_w  [$];
    logic [3:0]  exp_s  [$];
    logic [31:0] seen_w [$];
    logic [31:0] saved_w [$];
    logic [3:0]  first_strb;
    logic [7:0]  arlen_seen;

    // AXI read slave state
    bit          r_active;
    bit          r_took;
    int          r_idx;
    int          r_lastidx;
    logic [31:0] r_base;

    task automatic slave_clear();
        m_axi_arready = 1'b0;
        m_axi_rvalid  = 1'b0;
        m_axi_rlast   = 1'b0;
        m_axi_rdata   = 32'h0;
        r_active      = 1'b0;
        r_took        = 1'b0;
        r_idx         = 0;
    endtask

    // rdy_mode: 0 random, 1 toggle every cycle, 2 always ready
    // early   : slave raises rlast on the first beat
    // rst_beat: >=0 asserts reset once that many beats have been taken
    task automatic run_xfer(input logic [31:0] a, input int l, input int ar_dly,
                            input int rdy_mode, input bit early, input int rst_beat);
        int          o, exp_beats, exp_words, out_idx, ar_cnt, last_hs, budget;
        bit          finished;
        logic [31:0] w;
        logic [3:0]  s;

        o         = int'(a[1:0]);
        exp_beats = (o + l + 3) / 4;
        exp_words = (l + 3) / 4;
        exp_w.delete();
        exp_s.delete();
        seen_w.delete();
        for (int k = 0; k < exp_words; k++) begin
            w = '0;
            s = '0;
            for (int j = 0; j < 4; j++) begin
                if (4 * k + j < l) begin
                    w[8*j +: 8] = mem[(int'(a) + 4 * k + j) & 4095];
                    s[j] = 1'b1;
                end
            end
            exp_w.push_back(w);
            exp_s.push_back(s);
        end

        @(negedge clk);
        addr  = a;
        len   = 10'(l);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        check_val("busy_after_start", 32'(busy), 32'd1);

        out_idx  = 0;
        ar_cnt   = 0;
        last_hs  = -10;
        finished = 1'b0;
        budget   = 8 * exp_beats + 100;
        for (int cyc = 0; cyc < budget && !finished; cyc++) begin
            @(negedge clk);
            if (rst_beat >= 0 && r_active && r_idx >= rst_beat) begin
                rst = 1'b1;
                #1;
                check_val("rst_ctrl", {25'd0, busy, done, err, m_axi_arvalid,
                                       m_axi_rready, data_valid, data_last}, 32'd0);
                check_val("rst_data", data_out, 32'd0);
                check_val("rst_strb", 32'(data_strb), 32'd0);
                check_val("rst_araddr", m_axi_araddr, 32'd0);
                check_val("rst_arlen", 32'(m_axi_arlen), 32'd0);
                finished = 1'b1;
                slave_clear();
                @(negedge clk);
                rst = 1'b0;
            end else begin
                if (m_axi_arvalid) begin
                    m_axi_arready = (ar_cnt >= ar_dly);
                    ar_cnt++;
                end else begin
                    m_axi_arready = 1'b0;
                end
                if (r_took) begin
                    m_axi_rvalid = 1'b0;
                    m_axi_rlast  = 1'b0;
                    r_took       = 1'b0;
                end
                if (r_active && !m_axi_rvalid && $urandom_range(0, 3) != 0) begin
                    m_axi_rvalid = 1'b1;
                    for (int j = 0; j < 4; j++)
                        m_axi_rdata[8*j +: 8] = mem[(int'(r_base) + 4 * r_idx + j) & 4095];
                    m_axi_rlast = (r_idx == r_lastidx);
                end
                case (rdy_mode)
                    0:       data_ready = 1'($urandom_range(0, 1));
                    1:       data_ready = ~data_ready;
                    default: data_ready = 1'b1;
                endcase
                #1;
                if (m_axi_arvalid && m_axi_arready) begin
                    check_val("araddr", m_axi_araddr, {a[31:2], 2'b00});
                    check_val("arlen", 32'(m_axi_arlen), 32'(exp_beats - 1));
                    arlen_seen = m_axi_arlen;
                    r_base     = m_axi_araddr;
                    r_idx      = 0;
                    r_lastidx  = early ? 0 : int'(m_axi_arlen);
                    r_active   = 1'b1;
                end
                if (m_axi_rready && !data_ready)
                    check_val("rready_backpressure", 32'(o != 0 && r_idx == 0), 32'd1);
                if (data_valid && data_ready) begin
                    if (out_idx < exp_words) begin
                        check_val("data_out", data_out, exp_w[out_idx]);
                        check_val("data_strb", 32'(data_strb), 32'(exp_s[out_idx]));
                        check_val("data_last", 32'(data_last), 32'(out_idx == exp_words - 1));
                    end else begin
                        check_val("word_count", 32'(out_idx + 1), 32'(exp_words));
                    end
                    if (out_idx == 0) first_strb = data_strb;
                    seen_w.push_back(data_out);
                    out_idx++;
                    last_hs = cyc;
                end
                if (m_axi_rvalid && m_axi_rready) begin
                    r_took = 1'b1;
                    if (m_axi_rlast) r_active = 1'b0;
                    r_idx++;
                end
                if (done) begin
                    finished = 1'b1;
                    check_val("done_align", 32'(cyc), 32'(last_hs + 1));
                    check_val("err", 32'(err), 32'(early));
                    check_val("busy_at_done", 32'(busy), 32'd0);
                    check_val("words_out", 32'(out_idx), early ? 32'd1 : 32'(exp_words));
                end
            end
        end
        check_val("timeout", 32'(finished), 32'd1);
        slave_clear();
        $display("xfer addr=%h len=%0d arlen=%0d words=%0d err=%0b rst_beat=%0d",
                 a, l, arlen_seen, out_idx, err, rst_beat);
    endtask

    task automatic try_ignored(input logic [31:0] a, input int l, input string tag);
        @(negedge clk);
        addr  = a;
        len   = 10'(l);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_val(tag, {30'd0, busy, m_axi_arvalid}, 32'd0);
            @(negedge clk);
        end
        $display("xfer addr=%h len=%0d ignored busy=%0b", a, l, busy);
    endtask

    initial begin
        int          o, l, maxl;
        logic [31:0] a;

        rst        = 1'b1;
        start      = 1'b0;
        addr       = '0;
        len        = '0;
        data_ready = 1'b0;
        arlen_seen = '0;
        first_strb = '0;
        r_base     = '0;
        r_lastidx  = 0;
        slave_clear();
        for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);

        repeat (2) @(negedge clk);
        #1;
        check_val("reset_ctrl", {25'd0, busy, done, err, m_axi_arvalid,
                                 m_axi_rready, data_valid, data_last}, 32'd0);
        check_val("reset_data", data_out, 32'd0);
        check_val("reset_araddr", m_axi_araddr, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Aligned pass-through
        run_xfer(32'h100, 8, 0, 2, 1'b0, -1);
        check_val("tc1_arlen", 32'(arlen_seen), 32'd1);

        // Offset 1, one full word from two beats
        for (int i = 0; i < 8; i++) mem[12'h100 + i] = 8'(8'h11 * (i + 1));
        run_xfer(32'h101, 4, 0, 2, 1'b0, -1);
        check_val("tc2_arlen", 32'(arlen_seen), 32'd1);
        check_val("tc2_word", seen_w[0], 32'h55443322);
        check_val("tc2_strb", 32'(first_strb), 32'hF);

        // Offset 3, short tail
        mem[12'h100] = 8'hAA; mem[12'h101] = 8'hBB; mem[12'h102] = 8'hCC; mem[12'h103] = 8'hDD;
        mem[12'h104] = 8'h11; mem[12'h105] = 8'h22; mem[12'h106] = 8'h33; mem[12'h107] = 8'h44;
        run_xfer(32'h103, 3, 0, 2, 1'b0, -1);
        check_val("tc3_word", seen_w[0], 32'h002211DD);
        check_val("tc3_strb", 32'(first_strb), 32'h7);

        // Single beat ending in the flush word
        run_xfer(32'h102, 2, 0, 2, 1'b0, -1);
        check_val("tc4_arlen", 32'(arlen_seen), 32'd0);
        check_val("tc4_word", seen_w[0], 32'h0000DDCC);
        check_val("tc4_strb", 32'(first_strb), 32'h3);

        // Stalled run must give the same words as an unstalled one
        run_xfer(32'h101, 11, 3, 1, 1'b0, -1);
        saved_w = seen_w;
        run_xfer(32'h101, 11, 0, 2, 1'b0, -1);
        check_val("stall_count", 32'(saved_w.size()), 32'd3);
        for (int i = 0; i < 3 && i < saved_w.size() && i < seen_w.size(); i++)
            check_val("stall_vs_nostall", saved_w[i], seen_w[i]);

        // Early rlast on the first of three beats
        run_xfer(32'h200, 12, 0, 2, 1'b1, -1);

        // Reset in the middle of the data phase
        run_xfer(32'h301, 11, 0, 2, 1'b0, 1);

        // Requests that must be ignored
        try_ignored(32'h100, 0, "len_zero_ignored");
        try_ignored(32'h102, 1023, "overflow_ignored");

        // Largest bursts (256 beats)
        run_xfer(32'h003, 1021, 1, 0, 1'b0, -1);
        check_val("max_arlen", 32'(arlen_seen), 32'd255);
        run_xfer(32'h400, 1023, 0, 0, 1'b0, -1);
        run_xfer(32'h401, 1023, 2, 1, 1'b0, -1);

        // Randomized transfers
        for (int t = 0; t < 30; t++) begin
            a    = 32'($urandom_range(0, 2047));
            o    = int'(a[1:0]);
            maxl = (1024 - o > 1023) ? 1023 : 1024 - o;
            l    = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, maxl))
                                               : int'($urandom_range(1, 40));
            run_xfer(a, l, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 1'b0, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
